cic_decim_ctrl: RTL and testbench
=================================

# cic_decim_ctrl

Sequencer for the 1-bit-input CIC decimation chain. It gates the ±1 integrator cascade, counts input samples to generate the decimation strobe for the comb section, and discards the start-up transient. It captures comb results into a valid/ready output register with overrun detection. It sits between the PDM front end and the downstream DDC/FIR stage.

## Interface
- W, 19, integrator/comb/output data width
- RATIO_W, 8, width of decimation ratio
- ORDER, 3, CIC stage count; also the number of transient outputs discarded
- DEF_RATIO, 64, decimation ratio after reset
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  input PDM sample valid this cycle
- cfg_ratio  in  RATIO_W  new decimation ratio
- cfg_load  in  1  one-cycle pulse: apply cfg_ratio and restart chain
- integ_en  out  1  advance integrators this cycle
- integ_clr  out  1  synchronous clear of integrators and comb delay lines
- comb_strobe  out  1  one-cycle pulse: comb section processes current integrator value
- comb_data  in  W  comb output, valid in the cycle after comb_strobe
- out_data  out  W  decimated sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- overrun  out  1  sticky: a kept sample was dropped because the output was full

## Operation
- States: CLEAR, WARM, RUN. Reset enters CLEAR with ratio_reg=DEF_RATIO, cnt=0, warm_cnt=0.
- CLEAR lasts exactly 1 cycle:
  - integ_clr=1 (combinational from state, so 1 during reset); en ignored.
  - Next state WARM.
- integ_en = en && state!=CLEAR.
- Sample counter cnt (RATIO_W bits), WARM/RUN only:
  - On en, if cnt==ratio_reg-1 → cnt=0 and this is a wrap; else cnt+1.
  - en=0 holds cnt.
- comb_strobe is registered: high in the cycle after each wrap, in WARM and RUN.
- WARM: the first ORDER strobes prime the combs and are discarded; warm_cnt counts them. On the ORDER-th strobe → RUN.
- RUN: each strobe is kept. comb_data is registered at the end of the cycle after the strobe (capture cycle).
- Capture, when out_valid=0 or (out_valid && out_ready) in the capture cycle: out_data=comb_data, out_valid=1. Otherwise the new sample is dropped, the held sample is kept, and overrun=1.
- Handshake: transfer when out_valid && out_ready. out_valid falls the next cycle unless a capture refills it in the same cycle.
- cfg_load, any state:
  - Next state CLEAR; ratio_reg=max(cfg_ratio,2).
  - cnt, warm_cnt, out_valid and overrun cleared; any pending capture cancelled.
  - A cfg_load in the same cycle as a wrap suppresses that strobe.
- Ratio values 0 and 1 clamp to 2.
- cnt wraps only via the compare, never by overflow.

## Timing
- Reset values: integ_en=0, integ_clr=1, comb_strobe=0, out_data=0, out_valid=0, overrun=0.
- Latency from wrap sample (cycle t):
  - comb_strobe at t+1
  - comb_data sampled at t+2
  - out_valid at t+3
- Reset asserted mid-operation aborts immediately: all state returns to reset values, and a held output is lost.
- Throughput: one output per ratio_reg en-cycles. With ratio_reg ≥ 2, a strobe never overlaps the preceding capture.

## Structure
- Package cic_pkg holds:
  - state encoding localparams (CLEAR/WARM/RUN)
  - W and DEF_RATIO defaults
  - comb latency constant (1), shared with the comb datapath
- Sub-module cic_out_reg holds the valid/ready holding register and sticky overrun. Ports: clk, rst, flush, cap, din, out_data, out_valid, out_ready, overrun.
- Counter and FSM stay in the top.

## Test plan
- Reset release, ratio 4, ORDER 3, en=1 from cycle 1 → integ_clr=1 in cycle 0; comb_strobe in cycles 5, 9, 13, 17; only the 17 strobe is kept; out_valid rises in cycle 19 with the comb_data value from cycle 18.
- out_ready=0 held in RUN → the first sample is held; the next capture sets overrun=1 and out_data is unchanged. out_ready=1 in a capture cycle → new sample loaded, no overrun.
- cfg_ratio=1 with cfg_load → ratio 2; strobes every 2 en-cycles; en toggling 1/0 gives strobes every 4 clocks.
- cfg_load in the same cycle as a wrap, with out_valid=1 and overrun=1 → no strobe; next cycle integ_clr=1; out_valid=0, overrun=0; ORDER new strobes discarded.
- Async rst pulse mid-RUN, between strobe and capture → all outputs at reset values immediately; no out_valid from the cancelled capture.
- Ratio 255, en=1 for 255×5 cycles → exactly 5 strobes, 2 kept, cnt never exceeds 254.

Source files
------------

// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cic_pkg
//  Description : Shared constants and state encoding for the CIC decimator.
//  Revision    : 1.0 - initial release
// ============================================================================
package cic_pkg;

    localparam int CIC_W         = 19;
    localparam int CIC_DEF_RATIO = 64;
    // Cycles between comb_strobe and a valid comb output.
    localparam int COMB_LAT      = 1;

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_WARM  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    typedef enum logic [1:0] {
        ST_CLEAR = S_CLEAR,
        ST_WARM  = S_WARM,
        ST_RUN   = S_RUN
    } cic_state_e;

endpackage
`default_nettype wire

// File: rtl/cic_out_reg.sv
`default_nettype none
// ============================================================================
//  Module      : cic_out_reg
//  Description : Valid/ready holding register with sticky overrun flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module cic_out_reg #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         cap,
    input  logic [W-1:0] din,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overrun
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         ovr_q, ovr_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (flush) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else if (cap) begin
            // A same-cycle transfer frees the slot for the new sample.
            if (!valid_q || out_ready) begin
                data_d  = din;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule
`default_nettype wire

// File: rtl/cic_decim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cic_decim_ctrl
//  Description : CIC decimation sequencer: integrator gating, decimation
//                strobe, start-up transient discard and output capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module cic_decim_ctrl
    import cic_pkg::*;
#(
    parameter int W         = CIC_W,
    parameter int RATIO_W   = 8,
    parameter int ORDER     = 3,
    parameter int DEF_RATIO = CIC_DEF_RATIO
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic               cfg_load,
    output logic               integ_en,
    output logic               integ_clr,
    output logic               comb_strobe,
    input  logic [W-1:0]       comb_data,
    output logic [W-1:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overrun
);

    localparam int WARM_W = (ORDER > 1) ? $clog2(ORDER) : 1;

    cic_state_e         state_q, state_d;
    logic [RATIO_W-1:0] ratio_q, ratio_d;
    logic [RATIO_W-1:0] cnt_q, cnt_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic               strobe_q, strobe_d;
    logic               cap_q, cap_d;
    logic               w_active;
    logic               w_wrap;
    logic [RATIO_W-1:0] w_ratio_m1;

    always_comb begin
        w_active   = (state_q != ST_CLEAR);
        w_ratio_m1 = ratio_q - RATIO_W'(1);
        w_wrap     = w_active && en && (cnt_q == w_ratio_m1);

        state_d    = state_q;
        ratio_d    = ratio_q;
        cnt_d      = cnt_q;
        warm_cnt_d = warm_cnt_q;
        strobe_d   = w_wrap;
        // Comb output is ready COMB_LAT (one) cycle after a kept strobe.
        cap_d      = strobe_q && (state_q == ST_RUN);

        if (w_active && en) begin
            cnt_d = w_wrap ? '0 : cnt_q + RATIO_W'(1);
        end

        case (state_q)
            ST_CLEAR: state_d = ST_WARM;
            ST_WARM: begin
                if (strobe_q) begin
                    if (warm_cnt_q == WARM_W'(ORDER - 1)) begin
                        state_d = ST_RUN;
                    end else begin
                        warm_cnt_d = warm_cnt_q + WARM_W'(1);
                    end
                end
            end
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_CLEAR;
        endcase

        // Reconfiguration restarts the chain and wins over everything else.
        if (cfg_load) begin
            state_d    = ST_CLEAR;
            ratio_d    = (cfg_ratio < RATIO_W'(2)) ? RATIO_W'(2) : cfg_ratio;
            cnt_d      = '0;
            warm_cnt_d = '0;
            strobe_d   = 1'b0;
            cap_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            ratio_q    <= RATIO_W'(DEF_RATIO);
            cnt_q      <= '0;
            warm_cnt_q <= '0;
            strobe_q   <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ratio_q    <= ratio_d;
            cnt_q      <= cnt_d;
            warm_cnt_q <= warm_cnt_d;
            strobe_q   <= strobe_d;
            cap_q      <= cap_d;
        end
    end

    assign integ_en    = en && w_active;
    assign integ_clr   = !w_active;
    assign comb_strobe = strobe_q;

    cic_out_reg #(
        .W (W)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (cfg_load),
        .cap       (cap_q),
        .din       (comb_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cic_decim_ctrl
//  Description : Directed self-checking bench for cic_decim_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_decim_ctrl;

    localparam int W       = 19;
    localparam int RATIO_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [RATIO_W-1:0] cfg_ratio;
    logic               cfg_load;
    logic               integ_en;
    logic               integ_clr;
    logic               comb_strobe;
    logic [W-1:0]       comb_data;
    logic [W-1:0]       out_data;
    logic               out_valid;
    logic               out_ready;
    logic               overrun;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cic_decim_ctrl #(
        .W         (W),
        .RATIO_W   (RATIO_W),
        .ORDER     (3),
        .DEF_RATIO (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_ratio   (cfg_ratio),
        .cfg_load    (cfg_load),
        .integ_en    (integ_en),
        .integ_clr   (integ_clr),
        .comb_strobe (comb_strobe),
        .comb_data   (comb_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_strobe;
        int first_strobe;
        int n_valid;
        int last_data;
        int max_cnt;

        rst       = 1'b1;
        en        = 1'b1;
        cfg_ratio = '0;
        cfg_load  = 1'b0;
        comb_data = '0;
        out_ready = 1'b0;

        // Reset values
        step();
        step();
        check("rst_integ_en",   32'(integ_en),    32'd0);
        check("rst_integ_clr",  32'(integ_clr),   32'd1);
        check("rst_strobe",     32'(comb_strobe), 32'd0);
        check("rst_out_data",   32'(out_data),    32'd0);
        check("rst_out_valid",  32'(out_valid),   32'd0);
        check("rst_overrun",    32'(overrun),     32'd0);
        rst = 1'b0;
        en  = 1'b0;

        // Ratio 4 from a fresh CLEAR; warm-up, capture, overrun, refill
        step();
        cfg_load  = 1'b1;
        cfg_ratio = 8'd4;
        step();
        cfg_load = 1'b0;
        #1;
        check("c0_integ_clr", 32'(integ_clr), 32'd1);
        for (int c = 1; c <= 27; c++) begin
            step();
            en        = 1'b1;
            comb_data = W'(1000 + c);
            out_ready = (c == 26);
            #1;
            check($sformatf("r4_strobe_c%0d", c), 32'(comb_strobe), 32'((c >= 5) && (c % 4 == 1)));
            check($sformatf("r4_valid_c%0d", c),  32'(out_valid),   32'(c >= 19));
            check($sformatf("r4_data_c%0d", c),   32'(out_data),
                  (c < 19) ? 32'd0 : ((c < 27) ? 32'd1018 : 32'd1026));
            check($sformatf("r4_ovr_c%0d", c),    32'(overrun),     32'(c >= 23));
            if (c == 3) check("r4_integ_en", 32'(integ_en), 32'd1);
        end

        // cfg_load on a wrap cycle with a held sample and overrun set; ratio 1 clamps to 2
        step();
        out_ready = 1'b0;
        cfg_load  = 1'b1;
        cfg_ratio = 8'd1;
        comb_data = W'(1028);
        #1;
        check("ld_pre_valid",   32'(out_valid),   32'd1);
        check("ld_pre_overrun", 32'(overrun),     32'd1);
        step();
        cfg_load = 1'b0;
        #1;
        check("ld_no_strobe", 32'(comb_strobe), 32'd0);
        check("ld_integ_clr", 32'(integ_clr),   32'd1);
        check("ld_integ_en",  32'(integ_en),    32'd0);
        check("ld_valid",     32'(out_valid),   32'd0);
        check("ld_overrun",   32'(overrun),     32'd0);
        for (int d = 1; d <= 20; d++) begin
            step();
            en        = (d % 2 == 1);
            comb_data = W'(2000 + d);
            #1;
            check($sformatf("r2_strobe_d%0d", d), 32'(comb_strobe), 32'(d % 4 == 0));
            check($sformatf("r2_integ_en_d%0d", d), 32'(integ_en), 32'(d % 2 == 1));
            check($sformatf("r2_valid_d%0d", d),  32'(out_valid),   32'(d >= 18));
            if (d >= 18) check($sformatf("r2_data_d%0d", d), 32'(out_data), 32'd2017);
        end

        // Async reset between a kept strobe and its capture, with a held sample
        #2;
        rst = 1'b1;
        #1;
        check("arst_integ_clr", 32'(integ_clr),   32'd1);
        check("arst_integ_en",  32'(integ_en),    32'd0);
        check("arst_strobe",    32'(comb_strobe), 32'd0);
        check("arst_valid",     32'(out_valid),   32'd0);
        check("arst_data",      32'(out_data),    32'd0);
        check("arst_overrun",   32'(overrun),     32'd0);
        step();
        rst = 1'b0;
        en  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("arst_post_valid_%0d", k), 32'(out_valid), 32'd0);
        end

        // Ratio 255, 5 full periods
        cfg_load  = 1'b1;
        cfg_ratio = 8'd255;
        step();
        cfg_load     = 1'b0;
        n_strobe     = 0;
        first_strobe = 0;
        n_valid      = 0;
        last_data    = 0;
        max_cnt      = 0;
        for (int c = 1; c <= 1280; c++) begin
            step();
            en        = (c <= 1275);
            out_ready = 1'b1;
            comb_data = W'(3000 + c);
            #1;
            if (comb_strobe) begin
                n_strobe++;
                if (first_strobe == 0) first_strobe = c;
            end
            if (out_valid) begin
                n_valid++;
                last_data = int'(out_data);
            end
            if (int'(dut.cnt_q) > max_cnt) max_cnt = int'(dut.cnt_q);
        end
        check("r255_strobes",   32'(n_strobe),     32'd5);
        check("r255_first",     32'(first_strobe), 32'd256);
        check("r255_kept",      32'(n_valid),      32'd2);
        check("r255_last_data", 32'(last_data),    32'd4277);
        check("r255_max_cnt",   32'(max_cnt),      32'd254);
        check("r255_overrun",   32'(overrun),      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
